// File: rtl/relay_mode_arbiter.sv
// Chooses receiver or servo-driver channels for the A/E/R/T outputs from the AUX switch.
// Define RELAY_CC_EN to compile the cruise-control switch measurement and qualification.
module relay_mode_arbiter #(
    parameter int unsigned PW_MIN    = 40000,
    parameter int unsigned PW_MAX    = 110000,
    parameter int unsigned PW_THRESH = 75000,
    parameter int unsigned CONFIRM   = 3,
    parameter int unsigned STALE_CYC = 2500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       aux_pwm,
    input  logic       cc_pwm,
    input  logic [3:0] rx_lines,
    input  logic [3:0] sd_lines,
    output logic       sel_fc,
    output logic       cc_request,
    output logic [1:0] mode_state,
    output logic       sd_alive,
    output logic       led0
);
    localparam int unsigned PW_W   = 18;
    localparam int unsigned CONF_W = $clog2(CONFIRM + 1);
    localparam int unsigned WD_W   = $clog2(STALE_CYC + 1);
    localparam int unsigned LED_W  = 22;

    localparam logic [PW_W-1:0] PW_SAT   = '1;
    localparam logic [WD_W-1:0] WD_STALE = WD_W'(STALE_CYC);

    localparam logic [1:0] StRx       = 2'd0;
    localparam logic [1:0] StArm      = 2'd1;
    localparam logic [1:0] StFc       = 2'd2;
    localparam logic [1:0] StFailsafe = 2'd3;

    // Channel 0 is AUX; channel 1 (cruise control) exists only when enabled.
`ifdef RELAY_CC_EN
    localparam int NCH = 2;
`else
    localparam int NCH = 1;
`endif

    logic [NCH-1:0] pwm_raw;
`ifdef RELAY_CC_EN
    assign pwm_raw = {cc_pwm, aux_pwm};
`else
    logic unused_cc;
    assign unused_cc = cc_pwm;
    assign pwm_raw   = aux_pwm;
`endif

    logic [NCH-1:0]    pwm_meta_q, pwm_sync_q, pwm_prev_q;
    logic [7:0]        line_meta_q, line_sync_q;
    logic [3:0]        sd_prev_q;
    logic [PW_W-1:0]   width_q [NCH];
    logic [PW_W-1:0]   width_d [NCH];
    logic [CONF_W-1:0] conf_q [NCH];
    logic [CONF_W-1:0] conf_d [NCH];
    logic [NCH-1:0]    req_q, req_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic [1:0]        state_q, state_d;
    logic              sel_fc_q;
    logic              led_q, led_d;
    logic [LED_W-1:0]  led_cnt_q, led_cnt_d;
    logic              req_fc, gap, sd_rise;

    function automatic logic pw_valid(input logic [PW_W-1:0] w);
        return (w >= PW_W'(PW_MIN)) && (w <= PW_W'(PW_MAX));
    endfunction

    function automatic logic pw_high(input logic [PW_W-1:0] w);
        return w >= PW_W'(PW_THRESH);
    endfunction

    // width counts synchronised high cycles, including the rising one
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            width_d[i] = width_q[i];
            conf_d[i]  = conf_q[i];
            req_d[i]   = req_q[i];
            if (pwm_sync_q[i]) begin
                if (!pwm_prev_q[i]) begin
                    width_d[i] = PW_W'(1);
                end else if (width_q[i] != PW_SAT) begin
                    width_d[i] = width_q[i] + 1'b1;
                end
            end else if (pwm_prev_q[i]) begin
                if (!pw_valid(width_q[i]) || (pw_high(width_q[i]) == req_q[i])) begin
                    conf_d[i] = '0;
                end else if (conf_q[i] == CONF_W'(CONFIRM - 1)) begin
                    conf_d[i] = '0;
                    req_d[i]  = ~req_q[i];
                end else begin
                    conf_d[i] = conf_q[i] + 1'b1;
                end
            end
        end
    end

    assign sd_rise  = |(line_sync_q[3:0] & ~sd_prev_q);
    assign gap      = ~|line_sync_q;
    assign req_fc   = req_q[0];
    assign sd_alive = (wd_q < WD_STALE);

    always_comb begin
        wd_d = wd_q;
        if (sd_rise) begin
            wd_d = '0;
        end else if (wd_q != WD_STALE) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StRx: begin
                if (req_fc && sd_alive) state_d = StArm;
            end
            StArm: begin
                if (!req_fc || !sd_alive) state_d = StRx;
                else if (gap)             state_d = StFc;
            end
            StFc: begin
                if (!sd_alive)          state_d = StFailsafe;
                else if (!req_fc && gap) state_d = StRx;
            end
            StFailsafe: begin
                if (!req_fc) state_d = StRx;
            end
            default: state_d = StRx;
        endcase
    end

    // Blink phase restarts on every entry into ARM or FAILSAFE.
    always_comb begin
        led_d     = 1'b0;
        led_cnt_d = '0;
        case (state_d)
            StFc: led_d = 1'b1;
            StArm, StFailsafe: begin
                if (state_d == state_q) begin
                    led_cnt_d = led_cnt_q + 1'b1;
                    led_d     = (led_cnt_q == '1) ? ~led_q : led_q;
                end
            end
            default: led_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            pwm_meta_q  <= '0;
            pwm_sync_q  <= '0;
            pwm_prev_q  <= '0;
            line_meta_q <= '0;
            line_sync_q <= '0;
            sd_prev_q   <= '0;
            for (int i = 0; i < NCH; i++) begin
                width_q[i] <= '0;
                conf_q[i]  <= '0;
            end
            req_q     <= '0;
            wd_q      <= WD_STALE;
            state_q   <= StRx;
            sel_fc_q  <= 1'b0;
            led_q     <= 1'b0;
            led_cnt_q <= '0;
        end else begin
            pwm_meta_q  <= pwm_raw;
            pwm_sync_q  <= pwm_meta_q;
            pwm_prev_q  <= pwm_sync_q;
            line_meta_q <= {rx_lines, sd_lines};
            line_sync_q <= line_meta_q;
            sd_prev_q   <= line_sync_q[3:0];
            for (int i = 0; i < NCH; i++) begin
                width_q[i] <= width_d[i];
                conf_q[i]  <= conf_d[i];
            end
            req_q     <= req_d;
            wd_q      <= wd_d;
            state_q   <= state_d;
            sel_fc_q  <= (state_d == StFc);
            led_q     <= led_d;
            led_cnt_q <= led_cnt_d;
        end
    end

`ifdef RELAY_CC_EN
    logic cc_q;
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            cc_q <= 1'b0;
        end else begin
            cc_q <= (state_d == StFc) && req_d[1];
        end
    end
    assign cc_request = cc_q;
`else
    assign cc_request = 1'b0;
`endif

    assign sel_fc     = sel_fc_q;
    assign mode_state = state_q;
    assign led0       = led_q;

endmodule

// File: tb/tb_relay_mode_arbiter.sv
// Self-checking bench for relay_mode_arbiter: directed scenario steps with randomized widths
// and timing, compared every cycle against a rule-level reference model.
module tb_relay_mode_arbiter;
    localparam int PW_MIN    = 40;
    localparam int PW_MAX    = 110;
    localparam int PW_THRESH = 75;
    localparam int CONFIRM   = 3;
    localparam int STALE     = 500;
    localparam int SAT       = 262143;
`ifdef RELAY_CC_EN
    localparam int CC_ON = 1;
`else
    localparam int CC_ON = 0;
`endif

    logic       clk = 1'b0;
    logic       reset, aux_pwm, cc_pwm;
    logic [3:0] rx_lines, sd_lines;
    logic       sel_fc, cc_request, sd_alive, led0;
    logic [1:0] mode_state;

    int  n_checks = 0;
    int  n_pass   = 0;
    int  cyc      = 0;
    bit  chk_on   = 1'b0;
    bit  sd_run   = 1'b0;
    bit  sd_hi    = 1'b0;

    always #5 clk = ~clk;

    relay_mode_arbiter #(
        .PW_MIN    (PW_MIN),
        .PW_MAX    (PW_MAX),
        .PW_THRESH (PW_THRESH),
        .CONFIRM   (CONFIRM),
        .STALE_CYC (STALE)
    ) dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .aux_pwm    (aux_pwm),
        .cc_pwm     (cc_pwm),
        .rx_lines   (rx_lines),
        .sd_lines   (sd_lines),
        .sel_fc     (sel_fc),
        .cc_request (cc_request),
        .mode_state (mode_state),
        .sd_alive   (sd_alive),
        .led0       (led0)
    );

    // Reference model: pins become visible two edges late; widths, confirm runs, silence
    // and mode are tracked as plain integers following the behavioural rules.
    logic [9:0] hist[$];
    int m_run[2];
    int m_streak[2];
    bit m_req[2];
    int m_silence;
    int m_mode;

    function automatic int klass(input int w);
        if (w < PW_MIN || w > PW_MAX) return -1;
        return (w >= PW_THRESH) ? 1 : 0;
    endfunction

    always @(posedge clk) begin
        logic [9:0] pin, cur, prv;
        bit alive, gap, rq;
        int nxt, k, b;
        pin = {aux_pwm, cc_pwm, rx_lines, sd_lines};
        if (reset) begin
            hist.delete();
            repeat (3) hist.push_back(10'd0);
            for (int c = 0; c < 2; c++) begin
                m_run[c] = 0; m_streak[c] = 0; m_req[c] = 1'b0;
            end
            m_silence = STALE;
            m_mode    = 0;
        end else begin
            cur   = hist[1];
            prv   = hist[0];
            gap   = (cur[7:0] == 8'd0);
            alive = (m_silence < STALE);
            rq    = m_req[0];
            nxt   = m_mode;
            case (m_mode)
                0: if (rq && alive) nxt = 1;
                1: if (!rq || !alive) nxt = 0; else if (gap) nxt = 2;
                2: if (!alive) nxt = 3; else if (!rq && gap) nxt = 0;
                default: if (!rq) nxt = 0;
            endcase
            if ((cur[3:0] & ~prv[3:0]) != 4'd0) m_silence = 0;
            else if (m_silence < STALE) m_silence++;
            for (int c = 0; c < 2; c++) begin
                b = (c == 0) ? 9 : 8;
                if (cur[b]) begin
                    m_run[c] = prv[b] ? ((m_run[c] < SAT) ? m_run[c] + 1 : SAT) : 1;
                end else if (prv[b]) begin
                    k = klass(m_run[c]);
                    if (k < 0 || k == int'(m_req[c])) begin
                        m_streak[c] = 0;
                    end else begin
                        m_streak[c]++;
                        if (m_streak[c] == CONFIRM) begin
                            m_req[c]    = ~m_req[c];
                            m_streak[c] = 0;
                        end
                    end
                end
            end
            m_mode = nxt;
            hist.push_back(pin);
            void'(hist.pop_front());
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic check_all();
        int exp_cc;
        exp_cc = (CC_ON != 0 && m_mode == 2 && m_req[1]) ? 1 : 0;
        chk("model_mode", 32'(mode_state), m_mode);
        chk("model_sel", 32'(sel_fc), (m_mode == 2) ? 1 : 0);
        chk("model_cc", 32'(cc_request), exp_cc);
        chk("model_alive", 32'(sd_alive), (m_silence < STALE) ? 1 : 0);
        if (m_mode == 0) chk("model_led_rx", 32'(led0), 0);
        if (m_mode == 2) chk("model_led_fc", 32'(led0), 1);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            if (sd_run && (cyc % 100 == 0)) begin
                sd_hi    = !sd_hi;
                sd_lines = sd_hi ? 4'($urandom_range(1, 15)) : 4'd0;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
            if (chk_on) check_all();
        end
    endtask

    task automatic pulse(input bit ch, input int w, input int gap_cyc);
        if (ch) cc_pwm = 1'b1; else aux_pwm = 1'b1;
        tick(w);
        cc_pwm  = 1'b0;
        aux_pwm = 1'b0;
        tick(gap_cyc);
    endtask

    task automatic pulses(input bit ch, input int w, input int count);
        for (int i = 0; i < count; i++) pulse(ch, w, int'($urandom_range(20, 50)));
    endtask

    task automatic wait_mode(input logic [1:0] target, input int budget, input string tag);
        int n = 0;
        while (mode_state !== target && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(mode_state), 32'(target));
    endtask

    task automatic stop_sd();
        sd_run   = 1'b0;
        sd_hi    = 1'b0;
        sd_lines = 4'd0;
    endtask

    initial begin
        int n;
        reset = 1'b1; aux_pwm = 1'b0; cc_pwm = 1'b0; rx_lines = 4'd0; sd_lines = 4'd0;
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_sel", 32'(sel_fc), 0);
        chk("rst_mode", 32'(mode_state), 0);
        chk("rst_alive", 32'(sd_alive), 0);
        chk("rst_cc", 32'(cc_request), 0);
        reset = 1'b0;

        tick(600);
        chk("idle_sel", 32'(sel_fc), 0);
        chk("idle_mode", 32'(mode_state), 0);
        chk("idle_alive", 32'(sd_alive), 0);
        chk("idle_led", 32'(led0), 0);

        // Servo driver comes alive; two pulses are not enough, the third arms.
        sd_run = 1'b1;
        tick(300);
        chk("sd_alive_up", 32'(sd_alive), 1);
        pulses(1'b0, 90, 2);
        tick(20);
        chk("two_pulses_rx", 32'(mode_state), 0);
        pulse(1'b0, 90, 0);
        wait_mode(2'd1, 8, "arm_after_third");
        wait_mode(2'd2, 300, "fc_at_gap");

        // Servo driver silence forces failsafe; sel_fc lags sd_alive by one cycle.
        stop_sd();
        n = 0;
        while (sd_alive === 1'b1 && n < 800) begin tick(1); n++; end
        chk("alive_drop", 32'(sd_alive), 0);
        chk("sel_lag", 32'(sel_fc), 1);
        tick(1);
        chk("failsafe_sel", 32'(sel_fc), 0);
        chk("failsafe_mode", 32'(mode_state), 3);
        sd_run = 1'b1;
        tick(400);
        chk("failsafe_holds", 32'(mode_state), 3);
        pulses(1'b0, 60, 2);
        pulse(1'b0, 60, 0);
        wait_mode(2'd0, 8, "failsafe_exit");

        // Invalid pulse breaks the confirm run.
        pulse(1'b0, 90, 30);
        pulse(1'b0, 30, 30);
        pulses(1'b0, 90, 2);
        tick(20);
        chk("invalid_breaks_run", 32'(mode_state), 0);
        pulse(1'b0, 90, 0);
        wait_mode(2'd1, 8, "run_completes_arm");
        wait_mode(2'd2, 300, "run_completes_fc");

        // Cruise control request, then dropped together with sel_fc on failsafe.
        pulses(1'b1, 80, 3);
        tick(5);
        chk("cc_on", 32'(cc_request), CC_ON);
        stop_sd();
        n = 0;
        while (sel_fc === 1'b1 && n < 800) begin tick(1); n++; end
        chk("cc_leave_sel", 32'(sel_fc), 0);
        chk("cc_leave_cc", 32'(cc_request), 0);
        sd_run = 1'b1;
        pulses(1'b0, 60, 3);
        wait_mode(2'd0, 10, "recover_rx");
        pulses(1'b0, 90, 3);
        wait_mode(2'd2, 300, "recover_fc");

        // Reset from FC.
        reset = 1'b1;
        tick(1);
        chk("midrst_sel", 32'(sel_fc), 0);
        chk("midrst_mode", 32'(mode_state), 0);
        chk("midrst_cc", 32'(cc_request), 0);
        chk("midrst_alive", 32'(sd_alive), 0);
        chk("midrst_led", 32'(led0), 0);
        reset = 1'b0;
        tick(250);
        pulses(1'b0, 90, 3);
        wait_mode(2'd2, 300, "rearm_fc");

        // Return to RX waits for a gap on rx_lines too.
        rx_lines = 4'b0001;
        pulses(1'b0, 60, 3);
        tick(50);
        chk("no_gap_stays_fc", 32'(mode_state), 2);
        stop_sd();
        tick(5);
        rx_lines = 4'd0;
        tick(2);
        chk("gap_minus1", 32'(mode_state), 2);
        tick(1);
        chk("gap_rx", 32'(mode_state), 0);
        sd_run = 1'b1;

        // Width boundaries.
        pulses(1'b0, PW_THRESH - 1, 3);
        tick(10);
        chk("thresh_m1_low", 32'(mode_state), 0);
        pulse(1'b0, PW_THRESH, 30);
        pulse(1'b0, PW_MAX + 1, 30);
        pulses(1'b0, PW_THRESH, 2);
        tick(10);
        chk("above_max_invalid", 32'(mode_state), 0);
        pulse(1'b0, PW_MAX, 0);
        wait_mode(2'd1, 8, "max_valid_arm");
        wait_mode(2'd2, 300, "max_valid_fc");
        pulse(1'b0, PW_MIN, 30);
        pulse(1'b0, PW_MIN - 1, 30);
        pulses(1'b0, PW_MIN, 2);
        tick(10);
        chk("below_min_invalid", 32'(mode_state), 2);
        pulse(1'b0, PW_THRESH - 1, 0);
        wait_mode(2'd0, 300, "min_valid_rx");

        // Random soak.
        for (int i = 0; i < 40; i++) begin
            rx_lines = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            if ($urandom_range(0, 7) == 0) begin
                stop_sd();
                tick(600);
                sd_run = 1'b1;
            end
            pulse(1'($urandom_range(0, 1)), int'($urandom_range(20, 130)),
                  int'($urandom_range(10, 60)));
        end
        rx_lines = 4'd0;
        tick(300);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/relay_mode_arbiter.md
# relay_mode_arbiter

- Decides whether the four flight-control outputs (A, E, R, T) are driven by the receiver channels or by the servo-driver channels.
- The decision comes from the pilot's AUX switch (a PWM channel), gated by a liveness watchdog on the servo-driver outputs.
- Source changes happen only in an inter-pulse gap, and loss of the servo driver forces an immediate failsafe back to the receiver.
- The block sits between the input capture pins and the output routing mux, and also qualifies the cruise-control request to the RasPi.

## Interface
Parameters:
- PW_MIN, 40000: shortest valid pulse, in cycles (0.8 ms at 50 MHz).
- PW_MAX, 110000: longest valid pulse, in cycles (2.2 ms).
- PW_THRESH, 75000: pulse width at or above this is classed "high" (1.5 ms).
- CONFIRM, 3: consecutive identical valid classifications needed to change a request.
- STALE_CYC, 2500000: servo-driver silence that declares it dead (50 ms).

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- aux_pwm  in  1  AUX mode-switch PWM from the receiver (asynchronous).
- cc_pwm  in  1  cruise-control switch PWM from the receiver (asynchronous).
- rx_lines  in  4  receiver channels A, E, R, T (asynchronous).
- sd_lines  in  4  servo-driver channels A, E, R, T (asynchronous).
- sel_fc  out  1  1 = route sd_lines to the outputs; 0 = route rx_lines.
- cc_request  out  1  cruise-control request to the RasPi.
- mode_state  out  2  current state: 0 RX, 1 ARM, 2 FC, 3 FAILSAFE.
- sd_alive  out  1  servo-driver watchdog status.
- led0  out  1  status LED.

## Operation
- **Synchronisation:** every asynchronous input passes through a 2-FF synchroniser; all logic below uses the synchronised copies.
- **Pulse measurement (one per PWM input):**
  - An 18-bit high-time counter clears on the rising edge and saturates at 2^18-1.
  - On the falling edge the width W is classified: invalid if W<PW_MIN or W>PW_MAX, otherwise high if W≥PW_THRESH, else low.
  - Invalid pulses are discarded and reset the confirm count to 0.
  - A request bit (req_fc or req_cc) changes only after CONFIRM consecutive valid pulses that agree with each other and differ from its current value.
  - Both request bits reset to 0.
- **Watchdog:**
  - The counter clears on any rising edge of any sd_lines bit, otherwise increments and saturates at STALE_CYC.
  - sd_alive = (counter < STALE_CYC).
  - Reset preloads the counter to STALE_CYC, so sd_alive resets to 0.
- **Gap:** all 8 synchronised rx_lines and sd_lines are low in the same cycle.
- **State machine** (sel_fc is registered and equals 1 only in FC):
  - RX: if req_fc and sd_alive, go to ARM.
  - ARM: if req_fc=0 or sd_alive=0, go to RX. Otherwise, on gap, go to FC.
  - FC: sd_alive=0 takes priority and goes to FAILSAFE. Otherwise, if req_fc=0 and gap, go to RX. If req_fc=0 without a gap, stay in FC.
  - FAILSAFE: leave for RX only once req_fc=0 (the pilot must cycle the switch). Recovery of sd_alive alone does not exit.
- **cc_request:** equals req_cc registered, and is forced to 0 in every state except FC.
- **led0:** 0 in RX, 1 in FC, toggles every 2^22 cycles in ARM and FAILSAFE. The toggle counter clears on state entry.
- **Reset mid-operation:** every output and counter returns to its reset value on the next edge, whatever the state.
- **Reset values:** sel_fc=0, cc_request=0, mode_state=0 (RX), sd_alive=0, led0=0.

## Timing
- Input to internal visibility: 2 cycles (synchroniser).
- Falling edge at the pin to updated classification: 3 cycles. A request bit updates in the same cycle as its confirming classification.
- State change: 1 cycle after its condition is true. sel_fc and mode_state are registered outputs of the state, so they change together.
- FC→FAILSAFE: sel_fc falls 1 cycle after sd_alive falls. This transition does not wait for a gap.
- Simultaneous events:
  - In FC, sd_alive falling together with req_fc clearing goes to FAILSAFE.
  - In ARM, a gap together with sd_alive falling goes to RX.
- Pulse-width boundaries: W=PW_THRESH is high, W=PW_THRESH-1 is low, W=PW_MIN is valid, W=PW_MAX is valid, and a saturated counter is invalid.

## Configuration
- RELAY_CC_EN defined: cc_pwm is measured and cc_request behaves as described.
- RELAY_CC_EN undefined: the cc measurement logic is not compiled, cc_pwm is unused, and cc_request is tied to 0.

## Test plan
The bench overrides the parameters to PW_MIN=40, PW_MAX=110, PW_THRESH=75, CONFIRM=3, STALE_CYC=500.
- Reset, then hold all inputs low for 600 cycles → sel_fc=0, mode_state=0, sd_alive=0, led0=0.
- Toggle sd_lines every 100 cycles and send three aux pulses of 90 cycles → ARM after the third pulse, then FC at the first gap. Two pulses alone leave the block in RX.
- In FC, stop sd_lines → after 500 silent cycles sd_alive=0 and sel_fc falls 1 cycle later (mode 3). Restarting sd_lines keeps mode 3. Three aux pulses of 60 cycles → RX.
- Aux pulses of 90, 30 (invalid), 90, 90 → no change. A following 90 completes the confirm run → ARM.
- In FC, three cc pulses of 80 → cc_request=1. Leaving FC → cc_request=0 in the same cycle that sel_fc falls. Rebuilt without RELAY_CC_EN, cc_request stays 0.
- In FC, three aux pulses of 60 while rx_lines[0] stays high → remain in FC. Drop rx_lines[0] → RX 3 cycles later.
